// File: rtl/conv_subblock_reader.sv
// conv_subblock_reader
//   Drains the three subblock buffers of a convolutional encoder as a byte
//   stream: all of subblock 0, then 1, then 2, ascending byte index. Each
//   byte takes a REQ -> CAPT -> HOLD pass. That is three cycles per byte
//   when out_ready is held high.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   computation_done    encoder finished filling the buffers (starts a block)
//   blk_size            0: 132 bytes/subblock, 1: 768 bytes/subblock (latched at start)
//   q0, q1, q2          buffer read data, valid one cycle after the rdreq bit
//   rdreq_subblock      one-hot read request, bit k reads qk
//   out_data/out_sub    byte and its subblock index
//   out_valid/out_ready handshake; out_last marks the final byte of the block
//   busy                a block is being drained
//   blk_done            one-cycle pulse after the final handshake
//   blk_checksum        XOR of all block bytes, valid while blk_done is high
//
// Configuration
//   CONV_READER_CHECKSUM_EN  when defined, a running XOR accumulator drives
//                            blk_checksum; otherwise blk_checksum is 0.

module conv_subblock_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       computation_done,
  input  logic       blk_size,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic [2:0] rdreq_subblock,
  output logic [7:0] out_data,
  output logic [1:0] out_sub,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       blk_done,
  output logic [7:0] blk_checksum
);

  typedef enum logic [1:0] {IDLE, REQ, CAPT, HOLD} state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] sub_q, sub_d;
  logic       pend_q, pend_d;
  logic       size_q, size_d;
  logic       cd_q, cd_d;
  logic [7:0] data_q, data_d;
  logic [1:0] osub_q, osub_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       done_q, done_d;

  logic [9:0] last_idx;
  logic [7:0] q_sel;
  logic       start;
  logic       hs;
  logic       cd_rise;

  assign last_idx = size_q ? 10'd767 : 10'd131;
  assign start    = (state_q == IDLE) && (computation_done || pend_q);
  assign hs       = (state_q == HOLD) && out_ready;
  assign cd_d     = computation_done;
  assign cd_rise  = computation_done && !cd_q;

  // One request line per subblock; only asserted in REQ.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_rdreq
    assign rdreq_subblock[gi] = (state_q == REQ) && (sub_q == 2'(gi));
  end

  always_comb begin
    case (sub_q)
      2'd0:    q_sel = q0;
      2'd1:    q_sel = q1;
      2'd2:    q_sel = q2;
      default: q_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    pend_d  = pend_q;
    size_d  = size_q;
    data_d  = data_q;
    osub_d  = osub_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    // A new block announced while draining is remembered once; further
    // edges while pending are absorbed.
    if (cd_rise && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d  = blk_size;
          cnt_d   = 10'd0;
          sub_d   = 2'd0;
          pend_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = CAPT;
      end
      CAPT: begin
        data_d  = q_sel;
        osub_d  = sub_q;
        valid_d = 1'b1;
        last_d  = (sub_q == 2'd2) && (cnt_q == last_idx);
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (cnt_q < last_idx) begin
            cnt_d   = cnt_q + 10'd1;
            state_d = REQ;
          end else if (sub_q < 2'd2) begin
            cnt_d   = 10'd0;
            sub_d   = sub_q + 2'd1;
            state_d = REQ;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 10'd0;
      sub_q   <= 2'd0;
      pend_q  <= 1'b0;
      size_q  <= 1'b0;
      cd_q    <= 1'b0;
      data_q  <= 8'h00;
      osub_q  <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      pend_q  <= pend_d;
      size_q  <= size_d;
      cd_q    <= cd_d;
      data_q  <= data_d;
      osub_q  <= osub_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef CONV_READER_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;

  // Holds the final XOR through the blk_done cycle; only a new block start
  // clears it.
  always_comb begin
    acc_d = acc_q;
    if (start) begin
      acc_d = 8'h00;
    end else if (hs) begin
      acc_d = acc_q ^ data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign blk_checksum = acc_q;
`else
  assign blk_checksum = 8'h00;
`endif

  assign out_data  = data_q;
  assign out_sub   = osub_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign blk_done  = done_q;

endmodule

// File: tb/tb_conv_subblock_reader.sv
module tb_conv_subblock_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       computation_done;
  logic       blk_size;
  logic [7:0] q0, q1, q2;
  logic [2:0] rdreq_subblock;
  logic [7:0] out_data;
  logic [1:0] out_sub;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       busy;
  logic       blk_done;
  logic [7:0] blk_checksum;

  conv_subblock_reader dut (
    .clk              (clk),
    .reset            (reset),
    .computation_done (computation_done),
    .blk_size         (blk_size),
    .q0               (q0),
    .q1               (q1),
    .q2               (q2),
    .rdreq_subblock   (rdreq_subblock),
    .out_data         (out_data),
    .out_sub          (out_sub),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .blk_done         (blk_done),
    .blk_checksum     (blk_checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model parameters, changed only while the DUT is idle.
  int m_size = 0;
  int m_mode = 0;
  int rdy_mode = 0;

  function automatic logic [7:0] ram_byte(input int k, input int idx, input int mode);
    logic [7:0] b;
    case (mode)
      0:       b = 8'(((k & 3) << 6) | (idx & 63));
      1:       b = 8'hA5;
      default: b = (k == 0 && idx == 0) ? 8'h00 : 8'hA5;
    endcase
    return b;
  endfunction

  function automatic int per_sub(input int sz);
    return (sz != 0) ? 768 : 132;
  endfunction

  // Sequential-read buffer model: each request on bit k returns the next
  // byte of subblock k one cycle later; pointers rewind between blocks.
  int ptr[3];
  always @(posedge clk) begin
    if (reset || blk_done) begin
      for (int k = 0; k < 3; k++) ptr[k] <= 0;
      if (reset) begin
        q0 <= 8'h00; q1 <= 8'h00; q2 <= 8'h00;
      end
    end else begin
      if (rdreq_subblock[0]) begin q0 <= ram_byte(0, ptr[0], m_mode); ptr[0] <= ptr[0] + 1; end
      if (rdreq_subblock[1]) begin q1 <= ram_byte(1, ptr[1], m_mode); ptr[1] <= ptr[1] + 1; end
      if (rdreq_subblock[2]) begin q2 <= ram_byte(2, ptr[2], m_mode); ptr[2] <= ptr[2] + 1; end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode != 0) ? ((cyc % 4) == 0) : 1'b1;
  end

  // Monitor / scoreboard
  int         n_hs = 0;
  int         blocks_done = 0;
  int         last_done_cyc = 0;
  int         last_hs_cyc = -10;
  int         n_hs_at_done = 0;
  int         n_last = 0;
  int         n_last_at_done = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] last_cksum = 8'h00;
  logic [7:0] cap [0:2303];
  logic [1:0] capsub [0:2303];
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic [1:0] p_sub = 2'd0;
  logic       p_last = 1'b0;

  always @(negedge clk) begin : mon
    int per;
    int k;
    int idx;
    if (reset) begin
      n_hs    = 0;
      m_acc   = 8'h00;
      n_last  = 0;
      p_valid = 1'b0;
    end else begin
      per = per_sub(m_size);
      check("rdreq_onehot", 32'($countones(rdreq_subblock) <= 1), 1);
      if (!busy) check("rdreq_idle", rdreq_subblock, 0);
      if (p_valid && !p_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, p_data);
        check("hold_sub", out_sub, p_sub);
        check("hold_last", out_last, p_last);
      end
      if (out_valid) begin
        k   = n_hs / per;
        idx = n_hs % per;
        check("data", out_data, ram_byte(k, idx, m_mode));
        check("sub", out_sub, k);
        check("last", out_last, 32'(k == 2 && idx == per - 1));
        check("busy_valid", busy, 1);
        if (out_ready) begin
          if (n_hs < 2304) begin
            cap[n_hs]    = out_data;
            capsub[n_hs] = out_sub;
          end
          if (out_last) n_last++;
          m_acc       = m_acc ^ ram_byte(k, idx, m_mode);
          n_hs++;
          last_hs_cyc = cyc;
        end
      end else begin
        check("last_idle", out_last, 0);
      end
      if (blk_done) begin
        check("done_count", n_hs, 3 * per);
        check("done_timing", cyc, last_hs_cyc + 1);
`ifdef CONV_READER_CHECKSUM_EN
        check("checksum", blk_checksum, m_acc);
`else
        check("checksum", blk_checksum, 0);
`endif
        last_cksum     = blk_checksum;
        n_hs_at_done   = n_hs;
        n_last_at_done = n_last;
        last_done_cyc  = cyc;
        blocks_done++;
        n_hs   = 0;
        m_acc  = 8'h00;
        n_last = 0;
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_data  = out_data;
      p_sub   = out_sub;
      p_last  = out_last;
    end
  end

  // Stimulus helpers
  int start_cyc = 0;

  task automatic pulse_cd();
    @(posedge clk); #1;
    computation_done = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    computation_done = 1'b0;
  endtask

  task automatic wait_blocks(input int target, input int budget, input string what);
    int n = 0;
    while (blocks_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(what, 32'(blocks_done >= target), 1);
  endtask

  task automatic wait_hs(input int target, input int budget, input string what);
    int n = 0;
    while (n_hs < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(what, 32'(n_hs >= target), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdreq"}, rdreq_subblock, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_sub"}, out_sub, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, blk_done, 0);
    check({tag, "_cksum"}, blk_checksum, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    int started;
    int lat;
    reset = 1'b1;
    computation_done = 1'b0;
    blk_size = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: small block, ready always high
    m_size = 0; m_mode = 0; blk_size = 1'b0;
    pulse_cd();
    wait_blocks(1, 2000, "s1_timeout");
    lat = last_done_cyc - start_cyc;
    $display("s1: latency %0d cycles, %0d bytes", lat, n_hs_at_done);
    check("s1_latency", 32'(lat >= 1186 && lat <= 1190), 1);
    check("s1_bytes", n_hs_at_done, 396);
    check("s1_last_count", n_last_at_done, 1);
    check("s1_cap0", cap[0], 8'h00);
    check("s1_cap131", cap[131], 8'h03);
    check("s1_cap132", cap[132], 8'h40);
    check("s1_cap200", cap[200], 8'h44);
    check("s1_cap395", cap[395], 8'h83);

    // 2: large block
    m_size = 1; blk_size = 1'b1;
    pulse_cd();
    wait_blocks(2, 8000, "s2_timeout");
    $display("s2: %0d bytes", n_hs_at_done);
    check("s2_bytes", n_hs_at_done, 2304);
    check("s2_sub767", capsub[767], 0);
    check("s2_sub768", capsub[768], 1);
    check("s2_sub1535", capsub[1535], 1);
    check("s2_sub1536", capsub[1536], 2);

    // 3: throttled ready, blk_size flipped mid-block
    m_size = 0; blk_size = 1'b0; rdy_mode = 1;
    pulse_cd();
    wait_hs(50, 1000, "s3_hs_timeout");
    #1 blk_size = 1'b1;
    wait_blocks(3, 6000, "s3_timeout");
    rdy_mode = 0;
    blk_size = 1'b0;
    $display("s3: %0d bytes", n_hs_at_done);
    check("s3_bytes", n_hs_at_done, 396);
    check("s3_cap200", cap[200], 8'h44);
    check("s3_cap395", cap[395], 8'h83);

    // 4: computation_done during a block is queued
    pulse_cd();
    wait_hs(10, 200, "s4_hs_timeout");
    pulse_cd();
    wait_blocks(4, 2000, "s4_first_timeout");
    started = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (busy) begin
        started = 1;
        break;
      end
    end
    $display("s4: pending block started=%0d", started);
    check("s4_pend_restart", started, 1);
    wait_blocks(5, 2000, "s4_second_timeout");
    check("s4_bytes", n_hs_at_done, 396);

    // 5: reset mid-block aborts, new block starts fresh
    pulse_cd();
    wait_hs(200, 1000, "s5_hs_timeout");
    #1 reset = 1'b1;
    done_before = blocks_done;
    @(posedge clk);
    @(negedge clk);
    check_zero("s5_abort");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("s5_no_done", blocks_done, done_before);
    check("s5_not_resumed", busy, 0);
    pulse_cd();
    wait_blocks(done_before + 1, 2000, "s5_timeout");
    $display("s5: restart block %0d bytes", n_hs_at_done);
    check("s5_bytes", n_hs_at_done, 396);
    check("s5_cap0", cap[0], 8'h00);
    check("s5_sub0", capsub[0], 0);

    // 6: checksum patterns
    m_mode = 1;
    pulse_cd();
    wait_blocks(done_before + 2, 2000, "s6a_timeout");
    $display("s6a: checksum 0x%02h", last_cksum);
    check("s6a_cksum", last_cksum, 8'h00);
    m_mode = 2;
    pulse_cd();
    wait_blocks(done_before + 3, 2000, "s6b_timeout");
    $display("s6b: checksum 0x%02h", last_cksum);
`ifdef CONV_READER_CHECKSUM_EN
    check("s6b_cksum", last_cksum, 8'hA5);
`else
    check("s6b_cksum", last_cksum, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_subblock_reader.md
CONV_SUBBLOCK_READER -- requirements
Module: conv_subblock_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- computation_done  in  1  encoder has finished filling its three subblock buffers
- blk_size  in  1  0 = 1056-bit block (132 bytes per subblock), 1 = 6144-bit block (768 bytes per subblock); sampled at block start
- q0, q1, q2  in  8 each  subblock 0/1/2 buffer read data, valid 1 cycle after the matching rdreq bit
- rdreq_subblock  out  3  one-hot read request; bit k reads qk
- out_data  out  8  byte presented downstream
- out_sub  out  2  subblock index of out_data (0..2)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high
- out_last  out  1  high with the final byte of the block (subblock 2, last byte)
- busy  out  1  a block is being drained
- blk_done  out  1  one-cycle pulse after the last byte handshake
- blk_checksum  out  8  XOR of all block bytes, valid while blk_done is high

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, CAPT and HOLD.
REQ-004 In IDLE, when computation_done or pend is high, the FSM SHALL latch blk_size, clear the byte counter, set sub to 0, clear pend and go to REQ on the next cycle.
REQ-005 In REQ, rdreq_subblock SHALL be one-hot (1<<sub) for exactly one cycle, then the FSM SHALL go to CAPT.
REQ-006 In CAPT, q[sub] SHALL be registered into out_data, out_sub SHALL be set to sub, out_valid SHALL be set on the next edge, and the FSM SHALL go to HOLD.
REQ-007 In HOLD, out_data, out_sub, out_valid and out_last SHALL stay stable until out_ready is high.
REQ-008 On a HOLD handshake the block SHALL:
- clear out_valid
- if the byte counter is below last, increment it and go to REQ
- if the byte counter equals last and sub is below 2, clear the counter, increment sub and go to REQ
- otherwise pulse blk_done and go to IDLE
REQ-009 Last SHALL be 131 when the latched blk_size is 0 and 767 when it is 1; the counter SHALL be 10 bits.
REQ-010 Bytes SHALL leave in order: all of subblock 0, then all of subblock 1, then all of subblock 2, with the byte index ascending within each subblock.
REQ-011 out_last SHALL be high only while the byte with sub = 2 and counter = last is presented.
REQ-012 busy SHALL be low in IDLE and high in REQ, CAPT and HOLD.
REQ-013 A computation_done rising edge while busy SHALL set the pend flag, so the next block starts directly from IDLE; further edges while pend is set SHALL be dropped.
REQ-014 rdreq_subblock SHALL never have more than one bit set and SHALL be 0 outside REQ.
REQ-015 Minimum throughput SHALL be one byte per 3 cycles with out_ready held high.
REQ-016 A change of blk_size mid-block SHALL have no effect.

Reset
REQ-017 On reset the block SHALL go to IDLE and clear the following to 0: counter, sub, pend, rdreq_subblock, out_data, out_sub, out_valid, out_last, busy, blk_done and blk_checksum.
REQ-018 Reset asserted mid-block SHALL abort the block with no blk_done, and the partial block SHALL NOT be resumed.

Configuration
REQ-019 With the macro CONV_READER_CHECKSUM_EN defined, an 8-bit accumulator SHALL be cleared at block start and XORed with each byte on handshake, and blk_checksum SHALL show the final value during blk_done.
REQ-020 Without CONV_READER_CHECKSUM_EN, blk_checksum SHALL be tied to 0 and no accumulator SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- blk_size=0, qk returns (k<<6)|(idx&0x3F), out_ready=1 → 396 bytes in subblock order; out_last only on byte 396; blk_done 1 cycle after it; total latency 3*396 cycles ±2.
- blk_size=1 → 2304 bytes; out_sub changes at bytes 769 and 1537.
- blk_size=0 with out_ready toggling 1-of-4 → out_data/out_valid stable in HOLD; byte sequence same as the first scenario.
- computation_done pulses at byte 10 of the block → pend set; second block starts within 2 cycles of the first blk_done.
- reset asserted at byte 200 → all outputs 0 next cycle, no blk_done; a new computation_done restarts from subblock 0, byte 0.
- CHECKSUM_EN, all bytes 0xA5 for blk_size=0 → blk_checksum=0x00 (396 is even); with byte 0 set to 0x00 → 0xA5.
